// File: rtl/logic_pkg.sv
// Shared encodings and widths for the logic-unit sequencer (modes, FSM states, onehot helper).
// No logic of its own; imported by the interface, top and button sub-module.
package logic_pkg;

  localparam int NIB_W  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    MODE_AND = 2'd0,
    MODE_OR  = 2'd1,
    MODE_XOR = 2'd2,
    MODE_NOT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_SHOW    = 2'd2
  } state_e;

  // Bit i set for mode i; matches the {not, xor, or, and} enable ordering.
  function automatic logic [3:0] mode_onehot(input mode_e m);
    return 4'b0001 << m;
  endfunction

endpackage

// File: rtl/logic_op_sequencer_if.sv
// Operand/enable/result bundle between the sequencer (master) and the logic unit bank (slave).
// Purely combinational wiring; no handshake, the bank answers within the same cycle.
interface logic_op_sequencer_if;
  import logic_pkg::*;

  logic [NIB_W-1:0]  op_x;
  logic [NIB_W-1:0]  op_y;
  logic [BYTE_W-1:0] op_z;
  logic              en_and;
  logic              en_or;
  logic              en_xor;
  logic              en_not;
  logic [NIB_W-1:0]  and_res;
  logic [NIB_W-1:0]  or_res;
  logic [NIB_W-1:0]  xor_res;
  logic [BYTE_W-1:0] not_res;

  modport master (
    output op_x, op_y, op_z, en_and, en_or, en_xor, en_not,
    input  and_res, or_res, xor_res, not_res
  );

  modport slave (
    input  op_x, op_y, op_z, en_and, en_or, en_xor, en_not,
    output and_res, or_res, xor_res, not_res
  );

endinterface

// File: rtl/logic_op_sequencer_btn_pulse.sv
// Button front end: 2-flop sync, optional debouncer (LOGSEQ_DEBOUNCE_EN), falling-edge pulse.
// Press-to-pulse: 2 cycles, or 2+DEBOUNCE_CYCLES with the debouncer; one pulse per press.
module btn_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int          CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic lvl;

  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    prev_d  = lvl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

`ifdef LOGSEQ_DEBOUNCE_EN
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the sample disagrees; any agreeing sample restarts it.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign lvl = deb_q;
`else
  assign lvl = sync2_q;
`endif

  assign pulse = prev_q & ~lvl;

endmodule

// File: rtl/logic_op_sequencer.sv
// Mode/load sequencer for the logic unit bank; optional button debounce via LOGSEQ_DEBOUNCE_EN.
// Load pulse at T -> operands/enables after T, result + 1-cycle result_valid after T+1; no backpressure.
module logic_op_sequencer
  import logic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BYTE_W-1:0]     sw_in,
  input  logic                  btn_mode_n,
  input  logic                  btn_load_n,
  logic_op_sequencer_if.master  unit,
  output logic [1:0]            mode,
  output logic [BYTE_W-1:0]     result,
  output logic                  result_valid
);

  logic mode_p;
  logic load_p;

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_mode_btn (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_mode_n),
    .pulse (mode_p)
  );

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_load_btn (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_load_n),
    .pulse (load_p)
  );

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  mode_e             op_mode_q, op_mode_d;
  logic [NIB_W-1:0]  op_x_q, op_x_d;
  logic [NIB_W-1:0]  op_y_q, op_y_d;
  logic [BYTE_W-1:0] op_z_q, op_z_d;
  logic [3:0]        en_q, en_d;
  logic [BYTE_W-1:0] result_q, result_d;
  logic              result_valid_q, result_valid_d;

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    op_mode_d      = op_mode_q;
    op_x_d         = op_x_q;
    op_y_d         = op_y_q;
    op_z_d         = op_z_q;
    en_d           = en_q;
    result_d       = result_q;
    result_valid_d = 1'b0;

    if (mode_p && (state_q != S_CAPTURE)) begin
      mode_d = mode_e'(mode_q + 2'd1);
    end

    case (state_q)
      S_IDLE, S_SHOW: begin
        // Load captures the pre-increment mode when both buttons fire together.
        if (load_p) begin
          op_x_d    = sw_in[7:4];
          op_y_d    = sw_in[3:0];
          op_z_d    = sw_in;
          op_mode_d = mode_q;
          en_d      = mode_onehot(mode_q);
          state_d   = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        case (op_mode_q)
          MODE_AND: result_d = {{(BYTE_W-NIB_W){1'b0}}, unit.and_res};
          MODE_OR:  result_d = {{(BYTE_W-NIB_W){1'b0}}, unit.or_res};
          MODE_XOR: result_d = {{(BYTE_W-NIB_W){1'b0}}, unit.xor_res};
          default:  result_d = unit.not_res;
        endcase
        result_valid_d = 1'b1;
        state_d        = S_SHOW;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      mode_q         <= MODE_AND;
      op_mode_q      <= MODE_AND;
      op_x_q         <= '0;
      op_y_q         <= '0;
      op_z_q         <= '0;
      en_q           <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      op_mode_q      <= op_mode_d;
      op_x_q         <= op_x_d;
      op_y_q         <= op_y_d;
      op_z_q         <= op_z_d;
      en_q           <= en_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign unit.op_x   = op_x_q;
  assign unit.op_y   = op_y_q;
  assign unit.op_z   = op_z_q;
  assign unit.en_and = en_q[0];
  assign unit.en_or  = en_q[1];
  assign unit.en_xor = en_q[2];
  assign unit.en_not = en_q[3];
  assign mode         = mode_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Bench for logic_op_sequencer: unit bank modelled on the interface, results scoreboarded.
// Also exercises the debouncer when LOGSEQ_DEBOUNCE_EN is defined.
module tb_logic_op_sequencer;
  import logic_pkg::*;

`ifdef LOGSEQ_DEBOUNCE_EN
  localparam int DB   = 4;
  localparam int HOLD = 6;
`else
  localparam int DB   = 0;
  localparam int HOLD = 1;
`endif
  // Edge at which a press driven just after edge 0 is seen by the FSM.
  localparam int S = 3 + DB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw_in = 8'h00;
  logic       btn_mode_n = 1'b1;
  logic       btn_load_n = 1'b1;
  logic [1:0] mode;
  logic [7:0] result;
  logic       result_valid;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         rv_cnt = 0;
  logic [7:0] exp_q[$];
  logic [1:0] mode_exp = 2'd0;

  logic_op_sequencer_if unit_if();

  assign unit_if.and_res = unit_if.op_x & unit_if.op_y;
  assign unit_if.or_res  = unit_if.op_x | unit_if.op_y;
  assign unit_if.xor_res = unit_if.op_x ^ unit_if.op_y;
  assign unit_if.not_res = ~unit_if.op_z;

  logic_op_sequencer #(
    .DEBOUNCE_CYCLES((DB > 0) ? DB : 50000),
    .CNT_W          (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_in        (sw_in),
    .btn_mode_n   (btn_mode_n),
    .btn_load_n   (btn_load_n),
    .unit         (unit_if.master),
    .mode         (mode),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (result_valid === 1'b1) rv_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, limit 400000", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] en_vec();
    return {unit_if.en_not, unit_if.en_xor, unit_if.en_or, unit_if.en_and};
  endfunction

  function automatic logic [7:0] model(input logic [1:0] m, input logic [7:0] s);
    case (m)
      2'd0:    return {4'h0, s[7:4] & s[3:0]};
      2'd1:    return {4'h0, s[7:4] | s[3:0]};
      2'd2:    return {4'h0, s[7:4] ^ s[3:0]};
      default: return ~s;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit is_load, input int hold);
    if (is_load) begin
      exp_q.push_back(model(mode_exp, sw_in));
      btn_load_n = 1'b0;
    end else begin
      btn_mode_n = 1'b0;
    end
    step(hold);
    btn_load_n = 1'b1;
    btn_mode_n = 1'b1;
    if (!is_load) mode_exp = mode_exp + 2'd1;
  endtask

  task automatic wait_valid(output bit found, output logic [7:0] data);
    found = 1'b0;
    data  = 8'h00;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        found = 1'b1;
        data  = result;
        break;
      end
    end
  endtask

  task automatic pop_exp(output logic [7:0] e);
    if (exp_q.size() == 0) e = 8'hxx;
    else e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    int rv0;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    rv0 = rv_cnt;
    step(10);
    @(negedge clk);
    n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL reset_mode: got %0h want 0", mode); end
    n_cmp++; if (en_vec() !== 4'b0000) begin n_bad++; $display("FAIL reset_en: got %b want 0000", en_vec()); end
    n_cmp++; if (result !== 8'h00) begin n_bad++; $display("FAIL reset_result: got %h want 00", result); end
    n_cmp++; if (unit_if.op_z !== 8'h00) begin n_bad++; $display("FAIL reset_op_z: got %h want 00", unit_if.op_z); end
    n_cmp++; if (rv_cnt != rv0) begin n_bad++; $display("FAIL reset_no_valid: got %0d pulses want 0", rv_cnt - rv0); end
  endtask

  task automatic test_load_and();
    logic [7:0] e;
    sw_in = 8'hC3;
    step(1);
    exp_q.push_back(model(mode_exp, sw_in));
    btn_load_n = 1'b0;
    step(HOLD);
    btn_load_n = 1'b1;
    repeat (S + 1 - HOLD) @(negedge clk);
    n_cmp++; if (unit_if.op_x !== 4'hC) begin n_bad++; $display("FAIL and_op_x: got %h want c", unit_if.op_x); end
    n_cmp++; if (unit_if.op_y !== 4'h3) begin n_bad++; $display("FAIL and_op_y: got %h want 3", unit_if.op_y); end
    n_cmp++; if (unit_if.op_z !== 8'hC3) begin n_bad++; $display("FAIL and_op_z: got %h want c3", unit_if.op_z); end
    n_cmp++; if (en_vec() !== 4'b0001) begin n_bad++; $display("FAIL and_en: got %b want 0001", en_vec()); end
    n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL and_valid_early: got %b want 0", result_valid); end
    @(negedge clk);
    pop_exp(e);
    n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL and_valid: got %b want 1", result_valid); end
    n_cmp++; if (result !== e) begin n_bad++; $display("FAIL and_result: got %h want %h", result, e); end
    @(negedge clk);
    n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL and_valid_one_cycle: got %b want 0", result_valid); end
    n_cmp++; if (result !== e) begin n_bad++; $display("FAIL and_result_held: got %h want %h", result, e); end
  endtask

  task automatic test_mode_seq();
    logic [1:0] seq [5];
    logic [7:0] e, d;
    bit         found;
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      step(1);
      press(1'b0, HOLD + 1);
      step(S + 1);
      @(negedge clk);
      n_cmp++; if (mode !== seq[i]) begin n_bad++; $display("FAIL mode_step%0d: got %0d want %0d", i, mode, seq[i]); end
    end
    sw_in = 8'hA5;
    step(1);
    press(1'b1, HOLD);
    wait_valid(found, d);
    pop_exp(e);
    n_cmp++; if (!found) begin n_bad++; $display("FAIL or_timeout: got no result_valid want one"); end
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL or_result: got %h want %h", d, e); end
    n_cmp++; if (en_vec() !== 4'b0010) begin n_bad++; $display("FAIL or_en: got %b want 0010", en_vec()); end
  endtask

  task automatic test_not_hold();
    logic [7:0] e;
    int         rv0;
    step(1); press(1'b0, HOLD); step(S + 2);
    step(1); press(1'b0, HOLD); step(S + 2);
    sw_in = 8'h5A;
    rv0 = rv_cnt;
    step(1);
    press(1'b1, 20);
    step(10);
    pop_exp(e);
    n_cmp++; if (rv_cnt - rv0 != 1) begin n_bad++; $display("FAIL not_hold_pulses: got %0d want 1", rv_cnt - rv0); end
    n_cmp++; if (result !== e) begin n_bad++; $display("FAIL not_result: got %h want %h", result, e); end
    n_cmp++; if (en_vec() !== 4'b1000) begin n_bad++; $display("FAIL not_en: got %b want 1000", en_vec()); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] e, d;
    bit         found;
    repeat (3) begin
      step(1); press(1'b0, HOLD); step(S + 2);
    end
    sw_in = 8'h3C;
    step(1);
    exp_q.push_back(model(mode_exp, sw_in));
    btn_load_n = 1'b0;
    btn_mode_n = 1'b0;
    step(HOLD);
    btn_load_n = 1'b1;
    btn_mode_n = 1'b1;
    mode_exp = mode_exp + 2'd1;
    wait_valid(found, d);
    pop_exp(e);
    n_cmp++; if (!found) begin n_bad++; $display("FAIL simul_timeout: got no result_valid want one"); end
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL simul_result: got %h want %h", d, e); end
    n_cmp++; if (en_vec() !== 4'b0100) begin n_bad++; $display("FAIL simul_en: got %b want 0100", en_vec()); end
    n_cmp++; if (mode !== mode_exp) begin n_bad++; $display("FAIL simul_mode: got %0d want %0d", mode, mode_exp); end
  endtask

  task automatic test_mode_in_capture();
    logic [7:0] e, d;
    bit         found;
    sw_in = 8'h81;
    step(1);
    exp_q.push_back(model(mode_exp, sw_in));
    btn_load_n = 1'b0;
    step(1);
    btn_mode_n = 1'b0;
    step(HOLD - 1);
    btn_load_n = 1'b1;
    step(1);
    btn_mode_n = 1'b1;
    wait_valid(found, d);
    pop_exp(e);
    n_cmp++; if (!found) begin n_bad++; $display("FAIL capmode_timeout: got no result_valid want one"); end
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL capmode_result: got %h want %h", d, e); end
    step(S + 2);
    n_cmp++; if (mode !== mode_exp) begin n_bad++; $display("FAIL capmode_dropped: got %0d want %0d", mode, mode_exp); end
  endtask

  task automatic test_reset_capture();
    int rv0;
    rv0 = rv_cnt;
    sw_in = 8'hFF;
    step(1);
    btn_load_n = 1'b0;
    step(HOLD);
    btn_load_n = 1'b1;
    step(S - HOLD);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    mode_exp = 2'd0;
    step(8);
    n_cmp++; if (rv_cnt != rv0) begin n_bad++; $display("FAIL rstcap_valid: got %0d pulses want 0", rv_cnt - rv0); end
    n_cmp++; if (result !== 8'h00) begin n_bad++; $display("FAIL rstcap_result: got %h want 00", result); end
    n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL rstcap_mode: got %0d want 0", mode); end
    n_cmp++; if (en_vec() !== 4'b0000) begin n_bad++; $display("FAIL rstcap_en: got %b want 0000", en_vec()); end
  endtask

`ifdef LOGSEQ_DEBOUNCE_EN
  task automatic test_debounce();
    step(1);
    btn_mode_n = 1'b0;
    step(3);
    btn_mode_n = 1'b1;
    step(15);
    n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL deb_glitch: got %0d want 0", mode); end
    btn_mode_n = 1'b0;
    step(6);
    btn_mode_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL deb_early: got %0d want 0", mode); end
    @(negedge clk);
    n_cmp++; if (mode !== 2'd1) begin n_bad++; $display("FAIL deb_press: got %0d want 1", mode); end
    mode_exp = 2'd1;
  endtask
`endif

  initial begin
    test_reset();
    test_load_and();
    test_mode_seq();
    test_not_hold();
    test_simultaneous();
    test_mode_in_capture();
    test_reset_capture();
`ifdef LOGSEQ_DEBOUNCE_EN
    test_debounce();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
